led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Sequencing controller for the board LED bank. It divides `clock` by a switch-selected rate and steps a pattern register through one of four display modes, advanced by a push-button. It routes the pattern to the blue or green LED group, and sits between the switch/button inputs and the top-level LED outputs. It replaces free-running counter bits as the LED source.

## Interface
- `NB_LEDS`, 4: LED bank width; must be ≥ 2.
- `NB_COUNTER`, 16: prescaler counter width.
- `NB_SW`, 4: switch bus width; must be ≥ 4.
- `R0_LIMIT`, 3: terminal count for speed 0; all limits must be < 2^NB_COUNTER.
- `R1_LIMIT`, 7: terminal count for speed 1.
- `R2_LIMIT`, 15: terminal count for speed 2.
- `R3_LIMIT`, 31: terminal count for speed 3.
- `clock` in 1: single clock; all logic on its rising edge.
- `i_reset` in 1: reset is synchronous and active-high.
- `i_sw` in NB_SW:
  - [0] enable;
  - [2:1] speed select;
  - [3] colour, 0 = blue, 1 = green.
- `i_btn` in 1: mode-advance button; synchronous level.
- `o_led` out NB_LEDS: current pattern.
- `o_led_b` out NB_LEDS: pattern when colour = blue, else 0.
- `o_led_g` out NB_LEDS: pattern when colour = green, else 0.
- `o_tick` out 1: one-cycle pulse when the pattern steps.
- `o_mode` out 2: current mode.

## Operation
- **Prescaler**
  - When `i_sw[0]`=1, `count` increments each cycle.
  - When `count` ≥ limit[`i_sw[2:1]`], `count` clears to 0 and the pattern steps. The step period is limit+1 cycles.
  - The ≥ compare handles a speed lowered mid-count: the step happens on the next edge.
  - When `i_sw[0]`=0, `count` and the pattern hold their values; they do not clear.
- **Mode FSM**: SHIFT_L(0) → SHIFT_R(1) → BOUNCE(2) → FLASH(3) → SHIFT_L.
  - A mode advances on a rising edge of `i_btn`, detected as `i_btn & ~btn_d`.
  - The mode advances regardless of enable.
  - On advance, the pattern loads the new mode's initial value and `count` clears.
- **Patterns** (values shown for NB_LEDS=4)
  - SHIFT_L: init 0001, rotate left.
  - SHIFT_R: init 1000, rotate right.
  - BOUNCE: init 0001 with direction left. It reverses at the MSB and at the LSB: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - FLASH: init all-ones, toggles with 0000.
- **Colour gating**: `o_led_b` = `i_sw[3]`?0:pattern; `o_led_g` = `i_sw[3]`?pattern:0. Both are registered.
- **Simultaneous button edge and terminal count**: the mode advance wins. The pattern reloads and no `o_tick` is issued.

## Timing
- **Reset values**:
  - mode = SHIFT_L;
  - `count` = 0;
  - pattern / `o_led` = 0…01;
  - `o_led_b` = `o_led_g` = 0;
  - `o_tick` = 0;
  - direction = left;
  - `btn_d` = 1, so a button held through reset generates no advance.
- All outputs are registered.
- `o_tick`, `o_led`, `o_led_b` and `o_led_g` update on the same edge as the pattern step.
- A colour switch takes effect 1 cycle after `i_sw[3]` is sampled.
- A button edge sampled at edge N:
  - the new `o_mode` and initial pattern appear after edge N;
  - the first step follows limit+1 enabled cycles later.
- Reset asserted mid-operation overrides everything on that edge, including a pending tick or button edge.

## Configuration
- `LED_SEQ_MODE_EN` defined:
  - `i_btn` edge detector and 4-mode FSM are present, as described above.
- `LED_SEQ_MODE_EN` undefined:
  - mode is fixed to SHIFT_L;
  - `i_btn` is ignored (the port remains);
  - `o_mode` is constant 0;
  - the prescaler and colour gating are unchanged.

## Structure
- Shared header `led_seq_pkg.vh` holds:
  - mode encodings `MODE_SHIFT_L`, `MODE_SHIFT_R`, `MODE_BOUNCE`, `MODE_FLASH`;
  - default limit values.
- Sub-module `led_prescaler`:
  - inputs: enable, speed, the four limits, `clear`;
  - outputs: tick request.
- The mode FSM, pattern register and colour gating remain in `led_seq_ctrl`.

## Test plan
- **Speed 0, enabled.** Reset, then `i_sw`=4'b0001.
  - `o_tick` occurs every 4 cycles.
  - `o_led` sequence: 0001, 0010, 0100, 1000, 0001.
  - `o_led_b` equals `o_led`; `o_led_g` = 0.
- **Speed change.** Speed 3 with `count`=20; switch to speed 0.
  - Step on the next edge; subsequent period is 4 cycles.
- **Enable low.** Pull `i_sw[0]` low for 10 cycles mid-count.
  - `count`, `o_led` and `o_tick`=0 hold.
  - On re-enable, the remaining count resumes; no restart.
- **Mode advance.** Three `i_btn` pulses.
  - `o_mode` goes 1, 2, 3.
  - Pattern inits are 1000, 0001, 1111 respectively.
  - BOUNCE reverses at 1000; FLASH alternates 1111/0000.
- **Button coincides with terminal count.**
  - Mode advances, pattern reloads, `o_tick` stays 0.
  - Holding `i_btn` high through reset causes no advance.
- **Colour switch.** Set `i_sw[3]`=1 mid-run.
  - One cycle later, `o_led_b`=0 and `o_led_g`=`o_led`.
  - Build without `LED_SEQ_MODE_EN`: button pulses leave `o_mode`=0.

Source files
------------

// File: rtl/led_seq_ctrl_pkg.sv
// led_seq_ctrl_pkg: mode encodings, default prescaler limits and mode-order helper
package led_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_SHIFT_L = 2'd0,
    MODE_SHIFT_R = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_FLASH   = 2'd3
  } mode_e;
  localparam int DEF_R0_LIMIT = 3;
  localparam int DEF_R1_LIMIT = 7;
  localparam int DEF_R2_LIMIT = 15;
  localparam int DEF_R3_LIMIT = 31;
  function automatic mode_e mode_next(mode_e m);
    return mode_e'(m + 2'd1);
  endfunction
endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: switch/button inputs and LED/status outputs of the LED sequencer
interface led_seq_ctrl_if #(
  parameter int NB_LEDS = 4,
  parameter int NB_SW   = 4
);
  logic [NB_SW-1:0]   i_sw;
  logic               i_btn;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_b;
  logic [NB_LEDS-1:0] o_led_g;
  logic               o_tick;
  logic [1:0]         o_mode;
  modport master (output i_sw, i_btn, input o_led, o_led_b, o_led_g, o_tick, o_mode);
  modport slave  (input i_sw, i_btn, output o_led, o_led_b, o_led_g, o_tick, o_mode);
endinterface

// File: rtl/led_seq_ctrl_prescaler.sv
// led_prescaler: enable-gated counter that requests a step when count reaches the selected limit
module led_prescaler #(
  parameter int NB_COUNTER = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [1:0]            speed_i,
  input  logic [NB_COUNTER-1:0] lim0_i,
  input  logic [NB_COUNTER-1:0] lim1_i,
  input  logic [NB_COUNTER-1:0] lim2_i,
  input  logic [NB_COUNTER-1:0] lim3_i,
  input  logic                  clear_i,
  output logic                  tick_req_o
);
  logic [NB_COUNTER-1:0] count_q, count_d, lim;
  always_comb begin
    lim = speed_i == 2'd0 ? lim0_i : speed_i == 2'd1 ? lim1_i : speed_i == 2'd2 ? lim2_i : lim3_i;
    // >= so a speed lowered below the current count still steps on the next edge
    tick_req_o = en_i & (count_q >= lim);
    count_d = (clear_i | tick_req_o) ? '0 : en_i ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: prescaled LED pattern sequencer with colour routing;
// define LED_SEQ_MODE_EN to enable the button-driven 4-mode FSM (otherwise fixed SHIFT_L).
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int NB_LEDS    = 4,
  parameter int NB_COUNTER = 16,
  parameter int NB_SW      = 4,
  parameter int R0_LIMIT   = DEF_R0_LIMIT,
  parameter int R1_LIMIT   = DEF_R1_LIMIT,
  parameter int R2_LIMIT   = DEF_R2_LIMIT,
  parameter int R3_LIMIT   = DEF_R3_LIMIT
) (
  input logic           clock,
  input logic           i_reset,
  led_seq_ctrl_if.slave bus
);
  localparam logic [NB_LEDS-1:0] ONE = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] MSB = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] ALL = '1;
  mode_e              mode_q, mode_d;
  logic [NB_LEDS-1:0] pat_q, pat_d, init, step, led_b_q, led_g_q;
  logic               dir_q, dir_d, go_right, tick_q, tick_req, adv;
`ifdef LED_SEQ_MODE_EN
  logic btn_d_q;
  assign adv = bus.i_btn & ~btn_d_q;
`else
  assign adv = 1'b0;
`endif
  led_prescaler #(.NB_COUNTER(NB_COUNTER)) u_presc (
    .clk        (clock),
    .rst        (i_reset),
    .en_i       (bus.i_sw[0]),
    .speed_i    (bus.i_sw[2:1]),
    .lim0_i     (NB_COUNTER'(R0_LIMIT)),
    .lim1_i     (NB_COUNTER'(R1_LIMIT)),
    .lim2_i     (NB_COUNTER'(R2_LIMIT)),
    .lim3_i     (NB_COUNTER'(R3_LIMIT)),
    .clear_i    (adv),
    .tick_req_o (tick_req)
  );
  always_comb begin
    mode_d = adv ? mode_next(mode_q) : mode_q;
    init = mode_d == MODE_SHIFT_R ? MSB : mode_d == MODE_FLASH ? ALL : ONE;
    // bounce turns around when the lit bit reaches the end it is heading toward
    go_right = dir_q ? ~pat_q[0] : pat_q[NB_LEDS-1];
    step = mode_q == MODE_SHIFT_L ? {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]} :
           mode_q == MODE_SHIFT_R ? {pat_q[0], pat_q[NB_LEDS-1:1]} :
           mode_q == MODE_BOUNCE  ? (go_right ? pat_q >> 1 : pat_q << 1) : ~pat_q;
    pat_d = adv ? init : tick_req ? step : pat_q;
    dir_d = adv ? 1'b0 : (tick_req && mode_q == MODE_BOUNCE) ? go_right : dir_q;
  end
  always_ff @(posedge clock) begin
    if (i_reset) begin
      mode_q  <= MODE_SHIFT_L;
      pat_q   <= ONE;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      led_b_q <= '0;
      led_g_q <= '0;
`ifdef LED_SEQ_MODE_EN
      btn_d_q <= 1'b1;
`endif
    end else begin
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      tick_q  <= tick_req & ~adv;
      led_b_q <= bus.i_sw[3] ? '0 : pat_d;
      led_g_q <= bus.i_sw[3] ? pat_d : '0;
`ifdef LED_SEQ_MODE_EN
      btn_d_q <= bus.i_btn;
`endif
    end
  end
  assign bus.o_led   = pat_q;
  assign bus.o_led_b = led_b_q;
  assign bus.o_led_g = led_g_q;
  assign bus.o_tick  = tick_q;
  assign bus.o_mode  = mode_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed + random stimulus checked against a step-count reference model
module tb_led_seq_ctrl;
  localparam int N = 4;
`ifdef LED_SEQ_MODE_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  led_seq_ctrl_if #(.NB_LEDS(N), .NB_SW(4)) bus ();
  led_seq_ctrl dut (.clock(clk), .i_reset(rst), .bus(bus));
  int lim [4] = '{3, 7, 15, 31};
  int checks = 0;
  int errors = 0;
  int m_cnt, m_mode, m_k;
  bit m_btn_d, m_tick;
  logic [N-1:0] m_b, m_g;
  function automatic logic [N-1:0] pat_of(int mode, int k);
    int p;
    case (mode)
      0: return N'(1 << (k % N));
      1: return N'(1 << (N - 1 - k % N));
      2: begin
        p = k % (2 * N - 2);
        return N'(1 << (p < N ? p : 2 * N - 2 - p));
      end
      default: return (k % 2) ? N'(0) : {N{1'b1}};
    endcase
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(logic r, logic [3:0] sw, logic b);
    bit adv;
    @(negedge clk);
    rst = r;
    bus.i_sw = sw;
    bus.i_btn = b;
    if (r) begin
      m_cnt = 0; m_mode = 0; m_k = 0; m_btn_d = 1; m_tick = 0; m_b = '0; m_g = '0;
    end else begin
      adv = MEN && b && !m_btn_d;
      m_btn_d = b;
      m_tick = 0;
      if (adv) begin
        m_mode = (m_mode + 1) % 4; m_k = 0; m_cnt = 0;
      end else if (sw[0]) begin
        if (m_cnt >= lim[sw[2:1]]) begin
          m_cnt = 0; m_k++; m_tick = 1;
        end else m_cnt++;
      end
      m_b = sw[3] ? '0 : pat_of(m_mode, m_k);
      m_g = sw[3] ? pat_of(m_mode, m_k) : '0;
    end
    @(posedge clk);
    #1;
    check("o_led", 32'(bus.o_led), 32'(pat_of(m_mode, m_k)));
    check("o_led_b", 32'(bus.o_led_b), 32'(m_b));
    check("o_led_g", 32'(bus.o_led_g), 32'(m_g));
    check("o_tick", 32'(bus.o_tick), 32'(m_tick));
    check("o_mode", 32'(bus.o_mode), 32'(m_mode));
  endtask
  initial begin
    logic [3:0] sw;
    bus.i_sw = '0;
    bus.i_btn = 1'b1;
    repeat (3) cyc(1, 4'b0000, 1);
    repeat (2) cyc(0, 4'b0001, 1);
    repeat (20) cyc(0, 4'b0001, 0);
    repeat (21) cyc(0, 4'b0111, 0);
    repeat (10) cyc(0, 4'b0001, 0);
    repeat (5) cyc(0, 4'b0011, 0);
    repeat (10) cyc(0, 4'b0010, 0);
    repeat (12) cyc(0, 4'b0011, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b0001, 1);
      repeat (30) cyc(0, 4'b0001, 0);
    end
    for (int i = 0; i < 8 && m_cnt != lim[0]; i++) cyc(0, 4'b0001, 0);
    cyc(0, 4'b0001, 1);
    repeat (6) cyc(0, 4'b0001, 0);
    cyc(1, 4'b0001, 1);
    repeat (3) cyc(0, 4'b0001, 1);
    repeat (6) cyc(0, 4'b0001, 0);
    repeat (10) cyc(0, 4'b1001, 0);
    sw = 4'b0001;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        sw = 4'($urandom);
        sw[0] = ($urandom_range(7) != 0);
      end
      cyc($urandom_range(499) == 0, sw, $urandom_range(29) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
